// File: rtl/note_highway_pkg.sv
// note_highway_pkg: FSM states, pixel widths and RGB333 lane colour table for note_highway.
package note_highway_pkg;

    localparam int COLOUR_W  = 9;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int N_COLOURS = 5;

    typedef enum logic [2:0] {IDLE, ERASE, SHIFT, DRAW, DONE} state_e;

    localparam logic [COLOUR_W-1:0] C_BLACK  = 9'o000;
    localparam logic [COLOUR_W-1:0] C_GREEN  = 9'o070;
    localparam logic [COLOUR_W-1:0] C_RED    = 9'o700;
    localparam logic [COLOUR_W-1:0] C_YELLOW = 9'o770;
    localparam logic [COLOUR_W-1:0] C_BLUE   = 9'o007;
    localparam logic [COLOUR_W-1:0] C_ORANGE = 9'o740;

    localparam logic [COLOUR_W-1:0] LANE_COLOUR [N_COLOURS] =
        '{C_GREEN, C_RED, C_YELLOW, C_BLUE, C_ORANGE};

endpackage

// File: rtl/note_highway_beat_timer.sv
// beat_timer: wrapping 0..BEAT_PERIOD-1 counter with pause and a registered one-cycle beat pulse.
module beat_timer #(
    parameter int BEAT_PERIOD = 15000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pause,
    output logic o_beat
);

    localparam int CW = $clog2(BEAT_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(BEAT_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          beat_q, beat_d;

    always_comb begin
        cnt_d  = i_pause ? cnt_q : (cnt_q == LAST ? '0 : cnt_q + 1'b1);
        beat_d = !i_pause && cnt_q == LAST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            beat_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign o_beat = beat_q;

endmodule

// File: rtl/note_highway.sv
// note_highway: scrolling LANES x ROWS note grid, redrawn to a VGA plotter on every beat.
// Define NOTE_HIGHWAY_SCORE_EN to enable strum/fret hit detection and the score counter.
module note_highway
    import note_highway_pkg::*;
#(
    parameter int LANES       = 5,
    parameter int ROWS        = 8,
    parameter int BEAT_PERIOD = 15000000,
    parameter int X_ORIGIN    = 52,
    parameter int X_PITCH     = 52,
    parameter int Y_ORIGIN    = 8,
    parameter int Y_PITCH     = 28,
    parameter int BLOCK       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    i_notes,
    input  logic                i_notes_valid,
    input  logic                i_pause,
    input  logic [LANES-1:0]    i_frets,
    input  logic                i_strum,
    output logic [X_W-1:0]      o_x_VGA,
    output logic [Y_W-1:0]      o_y_VGA,
    output logic [COLOUR_W-1:0] o_colour_VGA,
    output logic                o_plot,
    output logic                o_beat,
    output logic [LANES-1:0]    o_notes_to_play,
    output logic                o_frame_done,
    output logic                o_overrun,
    output logic                o_hit,
    output logic [15:0]         o_score
);

    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int BW = BLOCK > 1 ? $clog2(BLOCK) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [BW-1:0] PX_LAST   = BW'(BLOCK - 1);
    localparam int X_MAX = X_ORIGIN + (LANES - 1) * X_PITCH + BLOCK - 1;
    localparam int Y_MAX = Y_ORIGIN + (ROWS - 1) * Y_PITCH + BLOCK - 1;

    if (X_MAX >= 2 ** X_W || Y_MAX >= 2 ** Y_W || ROWS < 2 || BLOCK < 1 || BEAT_PERIOD < 2) begin : g_bad_params
        $error("note_highway: parameters place pixels outside the 9-bit x / 8-bit y screen");
    end

    state_e                        state_q, state_d;
    logic [LW-1:0]                 lane_q, lane_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [BW-1:0]                 px_q, px_d, py_q, py_d;
    logic [LANES-1:0][ROWS-1:0]    grid_q, grid_d;
    logic [LANES-1:0]              stage_q, stage_d, shift_in;
    logic                          pending_q, pending_d, overrun_q, overrun_d;
    logic                          plot_q, plot_d, frame_done_q, frame_done_d;
    logic [X_W-1:0]                x_q, x_d;
    logic [Y_W-1:0]                y_q, y_d;
    logic [COLOUR_W-1:0]           colour_q, colour_d;
    logic [2:0]                    cidx;
    logic                          beat, scan, lit, cell_end, frame_end;

    beat_timer #(.BEAT_PERIOD(BEAT_PERIOD)) u_beat_timer (
        .clk    (clk),
        .reset  (reset),
        .i_pause(i_pause),
        .o_beat (beat)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        grid_d    = grid_q;
        lane_d    = lane_q;
        row_d     = row_q;
        px_d      = px_q;
        py_d      = py_q;
        stage_d   = i_notes_valid ? stage_q | i_notes : stage_q;
        shift_in  = stage_d;
        scan      = state_q == ERASE || state_q == DRAW;
        lit       = grid_q[lane_q][row_q];
        // Unlit cells in DRAW cost a single idle cycle instead of a full block scan.
        cell_end  = (px_q == PX_LAST && py_q == PX_LAST) || (state_q == DRAW && !lit);
        frame_end = cell_end && lane_q == LANE_LAST && row_q == ROW_LAST;
        if (scan) begin
            px_d   = cell_end || px_q == PX_LAST ? '0 : px_q + 1'b1;
            py_d   = cell_end ? '0 : (px_q == PX_LAST ? py_q + 1'b1 : py_q);
            lane_d = cell_end ? (lane_q == LANE_LAST ? '0 : lane_q + 1'b1) : lane_q;
            row_d  = cell_end && lane_q == LANE_LAST ? (row_q == ROW_LAST ? '0 : row_q + 1'b1) : row_q;
        end
        case (state_q)
            IDLE: if (beat || pending_q) begin
                state_d   = ERASE;
                pending_d = pending_q && beat;
            end
            ERASE: if (frame_end) state_d = SHIFT;
            SHIFT: begin
                state_d = DRAW;
                stage_d = '0;
                for (int l = 0; l < LANES; l++) grid_d[l] = {grid_q[l][ROWS-2:0], shift_in[l]};
            end
            DRAW: if (frame_end) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (beat && state_q != IDLE) begin
            pending_d = 1'b1;
            overrun_d = overrun_q | pending_q;
        end
        cidx         = 3'(int'(lane_q) % N_COLOURS);
        plot_d       = state_q == ERASE || (state_q == DRAW && lit);
        x_d          = X_W'(X_ORIGIN + int'(lane_q) * X_PITCH + int'(px_q));
        y_d          = Y_W'(Y_ORIGIN + int'(row_q) * Y_PITCH + int'(py_q));
        colour_d     = state_q == DRAW ? LANE_COLOUR[cidx] : C_BLACK;
        frame_done_d = state_q == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            row_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            grid_q       <= '0;
            stage_q      <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            row_q        <= row_d;
            px_q         <= px_d;
            py_q         <= py_d;
            grid_q       <= grid_d;
            stage_q      <= stage_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_bottom
        assign o_notes_to_play[n] = grid_q[n][ROWS-1];
    end

    assign o_x_VGA      = x_q;
    assign o_y_VGA      = y_q;
    assign o_colour_VGA = colour_q;
    assign o_plot       = plot_q;
    assign o_beat       = beat;
    assign o_frame_done = frame_done_q;
    assign o_overrun    = overrun_q;

`ifdef NOTE_HIGHWAY_SCORE_EN
    logic        strum_q, hit_q, hit_d, scored_q, scored_d;
    logic [15:0] score_q, score_d;

    always_comb begin
        hit_d    = i_strum && !strum_q && i_frets == o_notes_to_play && |o_notes_to_play && !scored_q;
        scored_d = state_q == SHIFT ? 1'b0 : scored_q | hit_d;
        score_d  = hit_d && score_q != 16'hFFFF ? score_q + 16'd1 : score_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strum_q  <= 1'b0;
            hit_q    <= 1'b0;
            scored_q <= 1'b0;
            score_q  <= '0;
        end else begin
            strum_q  <= i_strum;
            hit_q    <= hit_d;
            scored_q <= scored_d;
            score_q  <= score_d;
        end
    end

    assign o_hit   = hit_q;
    assign o_score = score_q;
`else
    logic unused_score_inputs;
    assign unused_score_inputs = ^{i_frets, i_strum};
    assign o_hit   = 1'b0;
    assign o_score = '0;
`endif

endmodule

// File: tb/tb_note_highway.sv
// tb_note_highway: directed bench for note_highway; hit/score expectations follow NOTE_HIGHWAY_SCORE_EN.
module tb_note_highway;

`ifdef NOTE_HIGHWAY_SCORE_EN
    localparam int HIT_EXP = 1;
`else
    localparam int HIT_EXP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_f, valid, pause, strum;
    logic [4:0]  notes, frets, play;
    logic [8:0]  x, col;
    logic [7:0]  y;
    logic        plot, beat, fd, ovr, hit;
    logic [15:0] score;

    logic [8:0]  f_x_unused, f_col_unused;
    logic [7:0]  f_y_unused;
    logic [4:0]  f_play_unused;
    logic [15:0] f_score_unused;
    logic        f_plot_unused, f_beat_unused, f_hit_unused, fd_f, ovr_f;

    note_highway #(.BEAT_PERIOD(2000)) dut (
        .clk(clk), .reset(rst), .i_notes(notes), .i_notes_valid(valid), .i_pause(pause),
        .i_frets(frets), .i_strum(strum), .o_x_VGA(x), .o_y_VGA(y), .o_colour_VGA(col),
        .o_plot(plot), .o_beat(beat), .o_notes_to_play(play), .o_frame_done(fd),
        .o_overrun(ovr), .o_hit(hit), .o_score(score)
    );

    note_highway #(.BEAT_PERIOD(300)) dut_f (
        .clk(clk), .reset(rst_f), .i_notes(5'b0), .i_notes_valid(1'b0), .i_pause(1'b0),
        .i_frets(5'b0), .i_strum(1'b0), .o_x_VGA(f_x_unused), .o_y_VGA(f_y_unused),
        .o_colour_VGA(f_col_unused), .o_plot(f_plot_unused), .o_beat(f_beat_unused),
        .o_notes_to_play(f_play_unused), .o_frame_done(fd_f), .o_overrun(ovr_f),
        .o_hit(f_hit_unused), .o_score(f_score_unused)
    );

    int n_cmp = 0, n_bad = 0;
    int f_lat, f_zero, f_lit;
    logic [8:0] f_xmin, f_xmax, f_col;
    logic [7:0] f_ymin, f_ymax;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!beat && n < limit);
        check("beat_seen", 32'(beat), 32'd1);
    endtask

    task automatic frame();
        f_lat = 0; f_zero = 0; f_lit = 0; f_col = '0;
        f_xmin = '1; f_xmax = '0; f_ymin = '1; f_ymax = '0;
        do begin
            step();
            f_lat++;
            if (plot && col == 9'd0) f_zero++;
            else if (plot) begin
                if (f_lit == 0) f_col = col;
                f_lit++;
                if (x < f_xmin) f_xmin = x;
                if (x > f_xmax) f_xmax = x;
                if (y < f_ymin) f_ymin = y;
                if (y > f_ymax) f_ymax = y;
            end
        end while (!fd && f_lat < 3000);
        check("frame_done_seen", 32'(fd), 32'd1);
    endtask

    task automatic beat_frame();
        int n;
        wait_beat(2100, n);
        frame();
    endtask

    task automatic strum_pulse(inout int hits);
        strum = 1'b1;
        step();
        if (hit) hits++;
        strum = 1'b0;
        repeat (3) begin
            step();
            if (hit) hits++;
        end
    endtask

    initial begin
        int n, pc, bc, hits, nfd, fd1, fd2;
        rst = 1; rst_f = 1; valid = 0; notes = '0; pause = 0; strum = 0; frets = '0;
        repeat (3) step();
        check("rst_plot", 32'(plot), 0);
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_colour", 32'(col), 0);
        check("rst_beat", 32'(beat), 0);
        check("rst_play", 32'(play), 0);
        check("rst_frame_done", 32'(fd), 0);
        check("rst_overrun", 32'(ovr), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_score", 32'(score), 0);
        rst = 0;

        // empty grid: first beat, full erase, 40 idle draw cycles
        wait_beat(2100, n);
        check("t1_first_beat_cycle", n, 2000);
        frame();
        check("t1_erase_plots", f_zero, 640);
        check("t1_lit_plots", f_lit, 0);
        check("t1_frame_len", f_lat, 683);
        step();
        check("t1_frame_done_single", 32'(fd), 0);
        check("t1_play", 32'(play), 0);

        // one note in lane 0 walks down the highway
        notes = 5'b00001; valid = 1; step(); valid = 0; notes = '0;
        for (int k = 1; k <= 9; k++) begin
            beat_frame();
            check("t2_lit_plots", f_lit, k <= 8 ? 16 : 0);
            if (k <= 8) check("t2_row_y", 32'(f_ymin), 8 + 28 * (k - 1));
            if (k == 1) begin
                check("t2_xmin", 32'(f_xmin), 52);
                check("t2_xmax", 32'(f_xmax), 55);
                check("t2_ymax", 32'(f_ymax), 11);
                check("t2_colour", 32'(f_col), 32'o070);
                check("t2_frame_len", f_lat, 698);
                check("t2_erase_plots", f_zero, 640);
            end
            if (k == 8) check("t2_play_beat8", 32'(play), 32'b00001);
            if (k == 9) check("t2_play_beat9", 32'(play), 0);
        end

        // bring 5'b00011 to the bottom row, then strum
        notes = 5'b00011; valid = 1; step(); valid = 0; notes = '0;
        for (int k = 1; k <= 8; k++) beat_frame();
        check("t6_play", 32'(play), 32'b00011);
        hits = 0;
        frets = 5'b00001;
        strum_pulse(hits);
        check("t6_wrong_frets_hits", hits, 0);
        check("t6_wrong_frets_score", 32'(score), 0);
        frets = 5'b00011;
        strum_pulse(hits);
        strum_pulse(hits);
        check("t6_hits", hits, HIT_EXP);
        check("t6_score", 32'(score), HIT_EXP);
        frets = '0;

        // staged notes from two cycles merge into one row
        notes = 5'b00100; valid = 1; step(); valid = 0; step();
        notes = 5'b10000; valid = 1; step(); valid = 0; notes = '0;
        beat_frame();
        check("t3_lit_plots", f_lit, 32);
        check("t3_xmin", 32'(f_xmin), 156);
        check("t3_xmax", 32'(f_xmax), 263);
        check("t3_ymin", 32'(f_ymin), 8);
        check("t3_ymax", 32'(f_ymax), 11);
        check("t3_first_colour", 32'(f_col), 32'o770);
        check("t3_frame_len", f_lat, 713);
        check("t3_play", 32'(play), 0);
        beat_frame();
        check("t3_next_lit_plots", f_lit, 32);
        check("t3_next_ymin", 32'(f_ymin), 36);

        // reset in the middle of an erase
        wait_beat(2100, n);
        pc = 0; n = 0;
        do begin
            step();
            n++;
            if (plot) pc++;
        end while (pc < 100 && n < 300);
        check("t5_reached_plot100", pc, 100);
        rst = 1;
        step();
        check("t5_plot", 32'(plot), 0);
        check("t5_x", 32'(x), 0);
        check("t5_y", 32'(y), 0);
        check("t5_colour", 32'(col), 0);
        check("t5_frame_done", 32'(fd), 0);
        check("t5_play", 32'(play), 0);
        check("t5_score", 32'(score), 0);
        check("t5_beat", 32'(beat), 0);
        rst = 0;
        pc = 0; bc = 0;
        repeat (1000) begin
            step();
            if (plot) pc++;
            if (beat) bc++;
        end
        check("t5_plots_after_reset", pc, 0);
        check("t5_beats_after_reset", bc, 0);

        // pause holds the beat counter
        pause = 1; bc = 0;
        repeat (3000) begin
            step();
            if (beat) bc++;
        end
        check("pause_beats", bc, 0);
        pause = 0;
        wait_beat(1100, n);
        check("pause_resume_cycle", n, 1000);

        // short beat period: pending, overrun and back-to-back frames
        rst_f = 0; nfd = 0; fd1 = 0; fd2 = 0;
        for (int c = 1; c <= 2400; c++) begin
            step();
            if (c == 899) check("t4_overrun_before", 32'(ovr_f), 0);
            if (c == 905) check("t4_overrun_set", 32'(ovr_f), 1);
            if (fd_f) begin
                nfd++;
                if (nfd == 1) fd1 = c;
                if (nfd == 2) fd2 = c;
            end
        end
        check("t4_first_frame_done", fd1, 983);
        check("t4_frame_gap", fd2 - fd1, 683);
        check("t4_frames", nfd, 3);
        check("t4_overrun_sticky", 32'(ovr_f), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
